// File: rtl/channel_sum_tree.sv
// channel_sum_tree: pipelined masked sum of NUM_CH signed channels, rounded, shifted and range-checked.
// Define SUM_SAT_EN to clamp out-of-range results instead of wrapping.
module channel_sum_tree #(
    parameter int NUM_CH   = 8,
    parameter int IN_W     = 32,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 17,
    parameter int LINE_LEN = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic [NUM_CH*IN_W-1:0]   din,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     ovf_clr,
    output logic signed [OUT_W-1:0]  dout,
    output logic                     data_valid,
    output logic                     line_done,
    output logic                     ovf
);
    localparam int LOG   = $clog2(NUM_CH);
    localparam int SUM_W = IN_W + LOG;
    localparam int EW    = (SUM_W + 1 > OUT_W ? SUM_W + 1 : OUT_W) + 1;
    localparam int CW    = $clog2(LINE_LEN + 1);
    localparam logic signed [EW-1:0] RND = (SHIFT == 0) ? '0 : ({{(EW-1){1'b0}}, 1'b1} << (SHIFT == 0 ? 0 : SHIFT - 1));
    localparam logic signed [EW-1:0] HI  = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] LO  = ~HI;
    // Heap-ordered tree: leaves at NUM_CH..2*NUM_CH-1, root at 1; every node is a register.
    logic signed [SUM_W-1:0] node_q [1:2*NUM_CH-1];
    logic [LOG:0] vld_q;
    logic signed [EW-1:0] ext, shf;
    logic oor, ovf_d;
    logic [OUT_W-1:0] res;
    logic [CW-1:0] cnt_q, cnt_d;
    logic last;
    logic signed [OUT_W-1:0] dout_q;
    logic dv_q, ld_q, ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 2*NUM_CH; i++) node_q[i] <= '0;
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[LOG-1:0], ce};
            for (int c = 0; c < NUM_CH; c++)
                if (ce) node_q[NUM_CH+c] <= ch_mask[c] ? SUM_W'($signed(din[c*IN_W +: IN_W])) : '0;
            for (int i = 1; i < NUM_CH; i++) node_q[i] <= node_q[2*i] + node_q[2*i+1];
        end
    end
    always_comb begin
        ext  = node_q[1];
        shf  = (ext + RND) >>> SHIFT;
        oor  = (shf > HI) || (shf < LO);
`ifdef SUM_SAT_EN
        res  = oor ? (shf[EW-1] ? LO[OUT_W-1:0] : HI[OUT_W-1:0]) : shf[OUT_W-1:0];
`else
        res  = shf[OUT_W-1:0];
`endif
        last  = cnt_q == CW'(LINE_LEN - 1);
        cnt_d = vld_q[LOG] ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
        ovf_d = (vld_q[LOG] && oor) || (ovf_q && !ovf_clr);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
            ld_q   <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            dout_q <= vld_q[LOG] ? res : dout_q;
            dv_q   <= vld_q[LOG];
            ld_q   <= vld_q[LOG] && last;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end
    assign dout       = dout_q;
    assign data_valid = dv_q;
    assign line_done  = ld_q;
    assign ovf        = ovf_q;
endmodule

// File: tb/tb_channel_sum_tree.sv
// tb_channel_sum_tree: scoreboard bench driving two DUTs (SHIFT=0 and SHIFT=4) with shared stimulus.
module tb_channel_sum_tree;
    logic clk = 0, rst = 1, ce = 0, ovf_clr = 0;
    logic [255:0] din = '0;
    logic [7:0] ch_mask = '0;
    logic [15:0] dout_a, dout_b;
    logic dv_a, dv_b, ld_a, ld_b, ovf_a, ovf_b;
    always #5 clk = ~clk;

    channel_sum_tree #(.NUM_CH(8), .IN_W(32), .OUT_W(16), .SHIFT(0), .LINE_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .din(din), .ch_mask(ch_mask), .ovf_clr(ovf_clr),
        .dout(dout_a), .data_valid(dv_a), .line_done(ld_a), .ovf(ovf_a));
    channel_sum_tree #(.NUM_CH(8), .IN_W(32), .OUT_W(16), .SHIFT(4), .LINE_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .din(din), .ch_mask(ch_mask), .ovf_clr(ovf_clr),
        .dout(dout_b), .data_valid(dv_b), .line_done(ld_b), .ovf(ovf_b));

    typedef struct { logic [15:0] a, b; bit oa, ob, ld; } exp_t;
    exp_t q[$];
    int checks = 0, fails = 0, line_cnt = 0, ld_seen = 0, dv_seen = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model(input logic [255:0] d, input logic [7:0] m, input int sh,
                                  output logic [15:0] o, output bit oor);
        longint s = 0;
        for (int c = 0; c < 8; c++) if (m[c]) s += longint'($signed(d[c*32 +: 32]));
        if (sh > 0) s += longint'(1) << (sh - 1);
        s = s >>> sh;
        oor = (s > 32767) || (s < -32768);
`ifdef SUM_SAT_EN
        o = oor ? (s > 0 ? 16'h7fff : 16'h8000) : s[15:0];
`else
        o = s[15:0];
`endif
    endfunction

    task automatic issue(input logic [255:0] d, input logic [7:0] m);
        exp_t e;
        @(posedge clk);
        #1;
        ce = 1; din = d; ch_mask = m;
        model(d, m, 0, e.a, e.oa);
        model(d, m, 4, e.b, e.ob);
        e.ld = (line_cnt % 4) == 3;
        line_cnt++;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ce = 0;
        end
    endtask

    task automatic run_one(input logic [255:0] d, input logic [7:0] m,
                           output logic [15:0] ra, output logic [15:0] rb, output int lat);
        issue(d, m);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            ce = 0;
            lat++;
        end while (!dv_a && lat < 20);
        ra = dout_a;
        rb = dout_b;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1; ce = 0; q.delete(); line_cnt = 0;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    function automatic logic [255:0] fill(input int v);
        logic [255:0] d;
        for (int c = 0; c < 8; c++) d[c*32 +: 32] = v;
        return d;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (dv_a || dv_b)) begin
            dv_seen++;
            chk("dv_b_vs_dv_a", dv_b, dv_a);
            if (q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_valid: got data_valid=1, expected none at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("dout_a", $signed(dout_a), $signed(e.a));
                chk("dout_b", $signed(dout_b), $signed(e.b));
                chk("line_done_a", ld_a, e.ld);
                chk("line_done_b", ld_b, e.ld);
                if (e.oa) chk("ovf_a_set", ovf_a, 1);
                if (e.ob) chk("ovf_b_set", ovf_b, 1);
                if (ld_a) ld_seen++;
            end
        end
    end

    initial begin
        logic [255:0] d;
        logic [15:0] ra, rb;
        int lat;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_dout_a", dout_a, 0); chk("rst_dv_a", dv_a, 0);
        chk("rst_ld_a", ld_a, 0);     chk("rst_ovf_a", ovf_a, 0);
        chk("rst_dout_b", dout_b, 0); chk("rst_dv_b", dv_b, 0);
        @(posedge clk);
        #1;
        rst = 0;

        for (int c = 0; c < 8; c++) d[c*32 +: 32] = c + 1;
        run_one(d, 8'hff, ra, rb, lat);
        chk("latency", lat, 5);
        chk("sum_1_to_8", $signed(ra), 36);
        chk("sum_1_to_8_shift4", $signed(rb), 2);

        run_one(fill(3), 8'hff, ra, rb, lat);
        chk("round_pos", $signed(rb), 2);
        run_one(fill(-3), 8'hff, ra, rb, lat);
        chk("round_neg", $signed(rb), -1);

        run_one(fill(100), 8'h01, ra, rb, lat);
        chk("mask_one", $signed(ra), 100);

        run_one(fill(5000), 8'hff, ra, rb, lat);
`ifdef SUM_SAT_EN
        chk("ovf_value", $signed(ra), 32767);
`else
        chk("ovf_value", $signed(ra), -25536);
`endif
        chk("ovf_set", ovf_a, 1);
        chk("ovf_b_clear", ovf_b, 0);
        @(posedge clk); #1; ovf_clr = 1;
        @(posedge clk); #1; ovf_clr = 0;
        chk("ovf_cleared", ovf_a, 0);

        issue(fill(5000), 8'hff);
        repeat (4) begin @(posedge clk); #1; ce = 0; end
        ovf_clr = 1;
        @(posedge clk); #1; ovf_clr = 0;
        chk("set_wins_dv", dv_a, 1);
        chk("set_wins_ovf", ovf_a, 1);

        do_reset();
        ld_seen = 0;
        repeat (9) issue(fill($urandom_range(0, 50)), 8'hff);
        idle(10);
        chk("line_done_count", ld_seen, 2);

        repeat (60) begin
            for (int c = 0; c < 8; c++)
                d[c*32 +: 32] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 4000) - 2000;
            issue(d, 8'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(10);
        chk("drained", q.size(), 0);

        issue(fill(7), 8'hff);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1; ce = 0; q.delete(); line_cnt = 0;
        #1;
        chk("flush_dout_a", dout_a, 0); chk("flush_dv_a", dv_a, 0);
        chk("flush_ld_a", ld_a, 0);     chk("flush_ovf_a", ovf_a, 0);
        chk("flush_dout_b", dout_b, 0); chk("flush_ovf_b", ovf_b, 0);
        dv_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        idle(10);
        chk("no_valid_after_rst", dv_seen, 0);
        chk("dout_a_after_rst", dout_a, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
